// File: rtl/apb_slave_mem.sv
// APB completer with a small word-wide register bank, programmable wait states
// and a slave error for word indices beyond DEPTH.
module apb_slave_mem #(
  parameter logic [1:0]  SLAVE_ID    = 2'b00,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0]  DepthLim = 7'(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      r_state, w_state_d;
  logic [5:0]  r_idx, w_idx_d;
  logic        r_wr, w_wr_d;
  logic [31:0] r_wd, w_wd_d;
  logic        r_err, w_err_d;
  logic [3:0]  r_cnt, w_cnt_d;

  logic [31:0] r_mem [DEPTH];
  logic        r_pready, w_pready_d;
  logic [31:0] r_prdata, w_prdata_d;
  logic        r_pslverr, w_pslverr_d;

  logic        w_sel;
  logic        w_unused;

  assign w_sel    = (psel == SLAVE_ID) && penable;
  // Upper address bits are decoded upstream; high index bit only feeds the error flag.
  assign w_unused = ^{paddr[7:6], r_idx};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_wr    <= 1'b0;
      r_wd    <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_wr    <= w_wr_d;
      r_wd    <= w_wd_d;
      r_err   <= w_err_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_wr_d    = r_wr;
    w_wd_d    = r_wd;
    w_err_d   = r_err;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_sel) begin
          w_idx_d   = paddr[5:0];
          w_wr_d    = pwrite;
          w_wd_d    = pwdata;
          w_err_d   = ({1'b0, paddr[5:0]} >= DepthLim);
          w_cnt_d   = WaitInit;
          w_state_d = (WaitInit == 4'd0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (!w_sel) begin
          w_state_d = StIdle;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_d = StAck;
          end
        end
      end
      StAck:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so they register in step with ACK.
  always_comb begin
    w_pready_d  = (w_state_d == StAck);
    w_pslverr_d = w_pready_d && w_err_d;
    w_prdata_d  = '0;
    if (w_pready_d && !w_wr_d && !w_err_d) begin
      w_prdata_d = r_mem[w_idx_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_mem     <= '{default: '0};
    end else begin
      r_pready  <= w_pready_d;
      r_prdata  <= w_prdata_d;
      r_pslverr <= w_pslverr_d;
      if (r_state == StAck && r_wr && !r_err) begin
        r_mem[r_idx[AW-1:0]] <= r_wd;
      end
    end
  end

  assign pready  = r_pready;
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench: three completers on one shared bus (IDs 00/01/11, waits 1/3/0).
module tb_apb_slave_mem;

  logic        clk;
  logic        rst;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;

  logic        rdy0, rdy1, rdy2;
  logic [31:0] rd0, rd1, rd2;
  logic        err0, err1, err2;

  int checks;
  int errors;

  apb_slave_mem #(.SLAVE_ID(2'b00), .DEPTH(32), .WAIT_CYCLES(1)) u_s0 (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy0), .prdata(rd0), .pslverr(err0)
  );

  apb_slave_mem #(.SLAVE_ID(2'b01), .DEPTH(32), .WAIT_CYCLES(3)) u_s1 (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy1), .prdata(rd1), .pslverr(err1)
  );

  apb_slave_mem #(.SLAVE_ID(2'b11), .DEPTH(32), .WAIT_CYCLES(0)) u_s2 (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(rdy2), .prdata(rd2), .pslverr(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_rdy(input int inst);
    if (inst == 0) return rdy0;
    else if (inst == 1) return rdy1;
    else return rdy2;
  endfunction

  function automatic logic [31:0] get_rd(input int inst);
    if (inst == 0) return rd0;
    else if (inst == 1) return rd1;
    else return rd2;
  endfunction

  function automatic logic get_err(input int inst);
    if (inst == 0) return err0;
    else if (inst == 1) return err1;
    else return err2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer; optionally scrambles master signals while waiting.
  task automatic xfer(input string tag, input int inst, input logic [1:0] sel,
                      input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input bit scramble);
    int          lat;
    logic [31:0] rd;
    logic        er;
    lat = 0;
    rd  = 32'h0;
    er  = 1'b0;
    psel = sel; penable = 1'b1; pwrite = wr; paddr = addr; pwdata = wd;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (get_rdy(inst)) begin
        lat = k;
        rd  = get_rd(inst);
        er  = get_err(inst);
        break;
      end
      if (scramble) begin
        paddr = addr ^ 8'h0E; pwdata = ~wd; pwrite = ~wr;
      end
    end
    penable = 1'b0; psel = 2'b00;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " prdata"}, rd, exp_rd);
    chk({tag, " pslverr"}, 32'(er), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, " pready pulse end"}, 32'(get_rdy(inst)), 32'h0);
  endtask

  task automatic watch(input int n, output int seen);
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (rdy0 || rdy1 || rdy2) seen++;
    end
  endtask

  int          seen;
  int          nrdy;
  logic [6:0]  pat;

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 8'h0; pwdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pready", 32'(rdy0), 32'h0);
    chk("reset prdata", rd0, 32'h0);
    chk("reset pslverr", 32'(err0), 32'h0);
    rst = 1'b1;

    // Dirty a word, then reset again and confirm the whole bank is cleared.
    xfer("pre write idx5", 0, 2'b00, 1'b1, 8'h05, 32'hCAFE_0005, 2, 32'h0, 1'b0, 1'b0);
    xfer("pre read idx5", 0, 2'b00, 1'b0, 8'h05, 32'h0, 2, 32'hCAFE_0005, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      xfer($sformatf("reset read idx%0d", i), 0, 2'b00, 1'b0, 8'(i), 32'h0, 2, 32'h0,
           1'b0, 1'b0);
    end

    // Basic write/read with one wait state; paddr[7:6] must be ignored.
    xfer("write 0x04", 0, 2'b00, 1'b1, 8'h04, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1'b0);
    xfer("read 0x04", 0, 2'b00, 1'b0, 8'h04, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    xfer("read 0xC4", 0, 2'b00, 1'b0, 8'hC4, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Index boundary: 31 is the last valid word, 32 and 37 are errors.
    xfer("write idx31", 0, 2'b00, 1'b1, 8'h1F, 32'h3131_3131, 2, 32'h0, 1'b0, 1'b0);
    xfer("read idx31", 0, 2'b00, 1'b0, 8'h1F, 32'h0, 2, 32'h3131_3131, 1'b0, 1'b0);
    xfer("read idx32", 0, 2'b00, 1'b0, 8'h20, 32'h0, 2, 32'h0, 1'b1, 1'b0);
    xfer("write idx37", 0, 2'b00, 1'b1, 8'h25, 32'h1234_5678, 2, 32'h0, 1'b1, 1'b0);
    xfer("read idx37", 0, 2'b00, 1'b0, 8'h25, 32'h0, 2, 32'h0, 1'b1, 1'b0);
    xfer("alias idx5 untouched", 0, 2'b00, 1'b0, 8'h05, 32'h0, 2, 32'h0, 1'b0, 1'b0);

    // Decode: psel=10 addresses nobody on this bus.
    psel = 2'b10; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03; pwdata = 32'h3333_3333;
    watch(8, seen);
    penable = 1'b0; psel = 2'b00;
    chk("decode no pready", 32'(seen), 32'h0);
    xfer("decode read idx3", 1, 2'b01, 1'b0, 8'h03, 32'h0, 4, 32'h0, 1'b0, 1'b0);

    // Abort by dropping penable mid-WAIT.
    psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    #1;
    penable = 1'b0; psel = 2'b00;
    watch(8, seen);
    chk("abort no pready", 32'(seen), 32'h0);
    xfer("abort read idx7", 1, 2'b01, 1'b0, 8'h07, 32'h0, 4, 32'h0, 1'b0, 1'b0);

    // Abort by reset mid-WAIT.
    psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 8'h07; pwdata = 32'hA5A5_A5A5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; penable = 1'b0; psel = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    watch(8, seen);
    chk("rst abort no pready", 32'(seen), 32'h0);
    xfer("rst abort read idx7", 1, 2'b01, 1'b0, 8'h07, 32'h0, 4, 32'h0, 1'b0, 1'b0);

    // Full three-wait transfer; signal changes while waiting must be ignored.
    xfer("w3 write idx7 scrambled", 1, 2'b01, 1'b1, 8'h07, 32'hA5A5_A5A5, 4, 32'h0, 1'b0,
         1'b1);
    xfer("w3 read idx7", 1, 2'b01, 1'b0, 8'h07, 32'h0, 4, 32'hA5A5_A5A5, 1'b0, 1'b0);
    xfer("w3 read idx9 untouched", 1, 2'b01, 1'b0, 8'h09, 32'h0, 4, 32'h0, 1'b0, 1'b0);

    // Back-to-back writes with zero wait states: pready every other cycle.
    pat  = 7'b1010100;
    nrdy = 0;
    psel = 2'b11; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 32'h1111_0001;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b pready cycle%0d", c), 32'(rdy2), 32'(pat[6-c]));
      if (rdy2) begin
        nrdy++;
        if (nrdy == 1) begin
          paddr = 8'h02; pwdata = 32'h2222_0002;
        end else if (nrdy == 2) begin
          paddr = 8'h03; pwdata = 32'h3333_0003;
        end else begin
          penable = 1'b0; psel = 2'b00;
        end
      end
    end
    penable = 1'b0; psel = 2'b00;
    xfer("b2b read idx1", 2, 2'b11, 1'b0, 8'h01, 32'h0, 1, 32'h1111_0001, 1'b0, 1'b0);
    xfer("b2b read idx2", 2, 2'b11, 1'b0, 8'h02, 32'h0, 1, 32'h2222_0002, 1'b0, 1'b0);
    xfer("b2b read idx3", 2, 2'b11, 1'b0, 8'h03, 32'h0, 1, 32'h3333_0003, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
